// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a synchronous instruction memory and
// aligns its one-cycle-late word with the matching PC at the IF/ID boundary.
`timescale 1ns/1ps
module fetch_unit #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = {PC_WIDTH{1'b0}},
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [PC_WIDTH-1:0]  redirect_pc,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [31:0]          imem_inst,
  output logic [31:0]          ifid_inst,
  output logic [PC_WIDTH-1:0]  ifid_pc,
  output logic                 ifid_valid,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0]  PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t              state_r;
  logic [PC_WIDTH-1:0] pc_r;
  logic [PC_WIDTH-1:0] pend_pc_r;
  logic                pend_valid_r;

  // Memory address mux; a stall replays the pending address so the memory keeps
  // returning the word that is still owed to decode.
  always_comb begin
    imem_addr = pc_r;
    if (!rst_n) begin
      imem_addr = RESET_PC;
    end else if (redirect) begin
      imem_addr = redirect_pc;
    end else if (stall) begin
      imem_addr = pend_pc_r;
    end else begin
      imem_addr = pc_r;
    end
  end

  // PC, pending-read tracking, IF/ID register, delivered counter and state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r         <= RESET_PC;
      pend_pc_r    <= RESET_PC;
      pend_valid_r <= 1'b0;
      ifid_inst    <= 32'd0;
      ifid_pc      <= {PC_WIDTH{1'b0}};
      ifid_valid   <= 1'b0;
      fetch_count  <= {CNT_WIDTH{1'b0}};
      state_r      <= FILL;
    end else if (redirect) begin
      pc_r         <= redirect_pc + PC_ONE;
      pend_pc_r    <= redirect_pc;
      pend_valid_r <= 1'b1;
      ifid_inst    <= 32'd0;
      ifid_valid   <= 1'b0;
      state_r      <= RUN;
    end else if (stall) begin
      case (state_r)
        FILL:    state_r <= FILL;
        RUN:     state_r <= HOLD;
        HOLD:    state_r <= HOLD;
        default: state_r <= HOLD;
      endcase
    end else begin
      ifid_inst    <= imem_inst;
      ifid_pc      <= pend_pc_r;
      ifid_valid   <= pend_valid_r;
      pend_pc_r    <= pc_r;
      pend_valid_r <= 1'b1;
      pc_r         <= pc_r + PC_ONE;
      state_r      <= RUN;
      if (pend_valid_r) begin
        fetch_count <= fetch_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected deliveries, monitors pop
// and compare on every advancing edge that presents a valid IF/ID word.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_addr, imem_inst, ifid_inst, ifid_pc;
  logic        ifid_valid;
  logic [15:0] fetch_count;

  logic        stall2 = 1'b0;
  logic        redirect2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'd0;
  logic [31:0] imem_addr2, imem_inst2, ifid_inst2, ifid_pc2;
  logic        ifid_valid2;
  logic [15:0] fetch_count2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .ifid_inst(ifid_inst), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
    .fetch_count(fetch_count)
  );

  fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFF), .CNT_WIDTH(16)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(stall2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .imem_addr(imem_addr2), .imem_inst(imem_inst2),
    .ifid_inst(ifid_inst2), .ifid_pc(ifid_pc2), .ifid_valid(ifid_valid2),
    .fetch_count(fetch_count2)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 + (a * 32'h0001_0001);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Synchronous instruction memories.
  always @(posedge clk) begin
    imem_inst  <= word(imem_addr);
    imem_inst2 <= word(imem_addr2);
  end

  logic [31:0] exp_q[$];
  logic [31:0] q2[$];
  logic        adv = 1'b0;
  logic        adv2 = 1'b0;
  int          exp_cnt = 0;
  int          exp_cnt2 = 0;

  always @(posedge clk) begin
    adv  <= rst_n && !stall && !redirect;
    adv2 <= rst_n;
  end

  // Monitor for the main instance.
  always @(negedge clk or negedge rst_n) begin : mon1
    logic [31:0] p;
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = 0;
    end else if (adv && ifid_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_delivery", {32'd0, ifid_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        p = exp_q.pop_front();
        check("ifid_pc", {32'd0, ifid_pc}, {32'd0, p});
        check("ifid_inst", {32'd0, ifid_inst}, {32'd0, word(p)});
        exp_cnt++;
        check("fetch_count", {48'd0, fetch_count}, {48'd0, exp_cnt[15:0]});
      end
    end
  end

  // Monitor for the wrapping-PC instance.
  always @(negedge clk or negedge rst_n) begin : mon2
    logic [31:0] p;
    if (!rst_n) begin
      q2.delete();
      exp_cnt2 = 0;
    end else if (adv2 && ifid_valid2 && q2.size() != 0) begin
      p = q2.pop_front();
      check("wrap_ifid_pc", {32'd0, ifid_pc2}, {32'd0, p});
      check("wrap_ifid_inst", {32'd0, ifid_inst2}, {32'd0, word(p)});
      exp_cnt2++;
      check("wrap_fetch_count", {48'd0, fetch_count2}, {48'd0, exp_cnt2[15:0]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_imem_addr"}, {32'd0, imem_addr}, 64'd0);
    check({tag, "_ifid_valid"}, {63'd0, ifid_valid}, 64'd0);
    check({tag, "_ifid_inst"}, {32'd0, ifid_inst}, 64'd0);
    check({tag, "_ifid_pc"}, {32'd0, ifid_pc}, 64'd0);
    check({tag, "_fetch_count"}, {48'd0, fetch_count}, 64'd0);
    check({tag, "_wrap_imem_addr"}, {32'd0, imem_addr2}, 64'h0000_0000_FFFF_FFFF);
  endtask

  initial begin
    #2;
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q = '{32'd0, 32'd1, 32'd2, 32'd3};
    q2    = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    step();  // edge 1: pipeline still empty
    check("fill_valid", {63'd0, ifid_valid}, 64'd0);
    check("fill_addr", {32'd0, imem_addr}, 64'd1);
    step();  // edge 2: A
    step();  // edge 3: B

    stall = 1'b1;
    #1;
    check("stall_addr", {32'd0, imem_addr}, 64'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_inst", {32'd0, ifid_inst}, {32'd0, word(32'd1)});
      check("stall_pc", {32'd0, ifid_pc}, 64'd1);
      check("stall_valid", {63'd0, ifid_valid}, 64'd1);
      check("stall_addr_hold", {32'd0, imem_addr}, 64'd2);
      check("stall_count", {48'd0, fetch_count}, 64'd2);
    end
    stall = 1'b0;
    step();  // C
    step();  // D

    redirect    = 1'b1;
    redirect_pc = 32'h20;
    #1;
    check("redirect_addr", {32'd0, imem_addr}, 64'h20);
    step();
    redirect = 1'b0;
    check("redirect_bubble_valid", {63'd0, ifid_valid}, 64'd0);
    check("redirect_bubble_inst", {32'd0, ifid_inst}, 64'd0);
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h21);
    step();
    step();

    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    stall    = 1'b0;
    redirect = 1'b0;
    check("stallredir_bubble_valid", {63'd0, ifid_valid}, 64'd0);
    check("stallredir_bubble_inst", {32'd0, ifid_inst}, 64'd0);
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h41);
    step();
    step();

    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    check("midreset_wrap_count", {48'd0, fetch_count2}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q = '{32'd0, 32'd1, 32'd2};
    for (int i = 0; i < 4; i++) begin
      step();
    end
    @(negedge clk);
    #1;
    check("queue_drained", {32'd0, exp_q.size()}, 64'd0);
    check("wrap_queue_drained", {32'd0, q2.size()}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that drives the word address into the synchronous instruction memory and consumes its one-cycle-late instruction word. It owns the program counter, handles decode-stage stalls and branch/jump redirects, and presents an aligned {instruction, PC, valid} triple to the IF/ID boundary. Its outputs feed the decode stage directly.

## Interface
- PC_WIDTH, 32, width of all PC/address values
- RESET_PC, 0, first word address fetched after reset
- CNT_WIDTH, 16, width of the delivered-instruction counter
- clk  input  1  rising-edge clock, shared with instruction memory
- rst_n  input  1  asynchronous, active-low reset
- stall  input  1  decode cannot accept; hold IF/ID contents
- redirect  input  1  single-cycle request to refetch from redirect_pc (branch/jump taken)
- redirect_pc  input  PC_WIDTH  target word address, sampled only when redirect=1
- imem_addr  output  PC_WIDTH  word address to instruction memory in_pc (combinational)
- imem_inst  input  32  instruction memory out_inst; holds imem[address presented in the previous cycle]
- ifid_inst  output  32  instruction to decode
- ifid_pc  output  PC_WIDTH  word address of ifid_inst
- ifid_valid  output  1  ifid_inst/ifid_pc hold a real instruction
- fetch_count  output  CNT_WIDTH  number of instructions delivered since reset, wraps modulo 2^CNT_WIDTH

## Operation
- Registers: pc (next address to issue), pend_pc/pend_valid (address currently being read by memory), ifid_inst/ifid_pc/ifid_valid, fetch_count, state.
- States: FILL (first cycle after reset, pipeline empty), RUN, HOLD (stall active).
- Address mux, priority order: redirect=1 -> redirect_pc; else stall=1 -> pend_pc (replay so memory keeps returning the pending word); else pc.
- Each rising edge, priority order:
  - redirect=1 (any state): pc <= redirect_pc+1; pend_pc <= redirect_pc; pend_valid <= 1; ifid_valid <= 0, ifid_inst <= 0 (flush wrong-path word); state <= RUN. Redirect overrides stall.
  - stall=1: pc, pend_*, ifid_* unchanged; state <= HOLD (FILL stays FILL).
  - otherwise: ifid_inst <= imem_inst; ifid_pc <= pend_pc; ifid_valid <= pend_valid; pend_pc <= pc; pend_valid <= 1; pc <= pc+1; state <= RUN; fetch_count += 1 iff pend_valid=1.
- Transitions: FILL -> RUN on first unstalled or redirected edge; RUN -> HOLD on stall; HOLD -> RUN on stall deassert or redirect.
- PC arithmetic: unsigned, modulo 2^PC_WIDTH; RESET_PC+1 etc. wrap 0xFFFFFFFF -> 0 without flag.
- fetch_count wraps to 0 after all-ones; never counts flushed or bubble slots.

## Timing
- Reset (asynchronous assert, any cycle): pc=RESET_PC, pend_pc=RESET_PC, pend_valid=0, ifid_inst=0, ifid_pc=0, ifid_valid=0, fetch_count=0, state=FILL; imem_addr=RESET_PC while rst_n=0. Deassertion is synchronous to clk by the system; first edge after deassert is an active edge.
- Latency: address issued in cycle t -> imem_inst valid in t+1 -> ifid_* valid in t+2 (two edges). Reset-to-first-valid: ifid_valid=1 after the 2nd edge following deassert.
- Throughput: one instruction per cycle with stall=0.
- Redirect penalty: one bubble (ifid_valid=0 for exactly one cycle), target instruction in ifid 2 edges after the redirect edge.
- Stall mid-stream: ifid_* frozen for every stalled cycle; on release the next ifid word is the one pending at stall onset, no skip, no duplicate.
- Simultaneous stall+redirect: redirect wins; flush still occurs.
- Reset mid-operation: all in-flight words discarded; fetch restarts at RESET_PC.

## Test plan
- Reset, imem[0..3]=A,B,C,D, no stall -> imem_addr 0,1,2,3...; ifid (A,0,1) after edge 2, (B,1,1) edge 3, (C,2,1) edge 4; fetch_count=3 after edge 4.
- Stall 3 cycles while ifid holds B -> ifid stays (B,1,1) for 3 cycles, imem_addr=2 during stall; after release ifid=C then D; no duplicate, fetch_count +1 per delivered word only.
- redirect=1, redirect_pc=0x20 while ifid holds C -> next cycle ifid_valid=0, ifid_inst=0; following cycle ifid=(imem[0x20],0x20,1), then 0x21.
- stall=1 and redirect=1 same cycle (target 0x40) -> redirect taken, one bubble, ifid=(imem[0x40],0x40,1) two edges later.
- RESET_PC=0xFFFFFFFF -> ifid_pc sequence 0xFFFFFFFF, 0x00000000, 0x00000001.
- rst_n pulsed low mid-stream (asynchronously, between edges) -> all outputs zero immediately, imem_addr=RESET_PC, fetch_count=0; refill as first scenario.
